display_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480@60 display controller: generates scan position, sync and blanking for any mode set by parameters.
- Adds a pixel-enable divider, run/stop control, configurable sync polarity, line/frame start strobes and a frame counter.
- Sits between the system clock and the pixel pipeline (tile/sprite renderers, VGA DAC).

---
 rtl/display_timing_gen.sv | 200 ++++++++++++++++++++
 tb/tb_display_timing_gen.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// -----------------------------------------------------------------------------
// display_timing_gen
//
// Parametrised raster timing generator. Divides the system clock down to a
// pixel rate, walks a (h_pos, v_pos) scan position through a full frame and
// decodes sync, blanking and line/frame strobes from that position.
// Position 0 on each axis is the start of the sync pulse, followed by back
// porch, visible region and front porch.
//
// Every output is registered and decoded from the next-state position, so
// status outputs always agree with h_pos/v_pos in the same cycle.
// line_start, frame_start and pix_en show up in the cycle the new position
// first appears. The reset position (0,0) is shown without strobes.
//
// Optional feature (macro DISPLAY_TIMING_LINE_IRQ_EN):
//   adds line_cmp / line_irq, a one-clk pulse alongside line_start when the
//   new v_pos equals line_cmp. When the macro is undefined, neither port
//   exists and no compare logic is built.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       run when high; freeze all state when low
//   pix_en       one-clk strobe per pixel period
//   h_pos/v_pos  scan position (0 = start of sync)
//   hsync/vsync  sync outputs, active level set by HSYNC_POL/VSYNC_POL
//   hblank       high outside the visible columns
//   vblank       high outside the visible lines
//   line_start   pulse when h_pos wraps to 0
//   frame_start  pulse when (h_pos, v_pos) wraps to (0, 0)
//   frame_count  completed-frame counter (wraps modulo 2^FRAME_COUNT_WIDTH)
//   line_cmp     (optional) line number that raises line_irq
//   line_irq     (optional) pulse when the new v_pos equals line_cmp
// -----------------------------------------------------------------------------
module display_timing_gen #(
    parameter int HCOUNT_WIDTH      = 10,
    parameter int VCOUNT_WIDTH      = 10,
    parameter int H_SYNC            = 96,
    parameter int H_BACK            = 48,
    parameter int H_VISIBLE         = 640,
    parameter int H_FRONT           = 16,
    parameter int V_SYNC            = 2,
    parameter int V_BACK            = 33,
    parameter int V_VISIBLE         = 480,
    parameter int V_FRONT           = 10,
    parameter int CLK_DIV           = 2,
    parameter bit HSYNC_POL         = 1'b0,
    parameter bit VSYNC_POL         = 1'b0,
    parameter int FRAME_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
    input  logic [VCOUNT_WIDTH-1:0]      line_cmp,
    output logic                         line_irq,
`endif
    output logic                         pix_en,
    output logic [HCOUNT_WIDTH-1:0]      h_pos,
    output logic [VCOUNT_WIDTH-1:0]      v_pos,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         hblank,
    output logic                         vblank,
    output logic                         line_start,
    output logic                         frame_start,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int HVIS0   = H_SYNC + H_BACK;
    localparam int HVIS1   = HVIS0 + H_VISIBLE;
    localparam int VVIS0   = V_SYNC + V_BACK;
    localparam int VVIS1   = VVIS0 + V_VISIBLE;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HCOUNT_WIDTH-1:0] H_LAST   = HCOUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [VCOUNT_WIDTH-1:0] V_LAST   = VCOUNT_WIDTH'(V_TOTAL - 1);

    // Mode sanity: counters must reach the last column/line of the frame.
    if (longint'(H_TOTAL - 1) >= (longint'(1) << HCOUNT_WIDTH)) begin : g_h_width_err
        $error("display_timing_gen: HCOUNT_WIDTH too small for H_TOTAL-1");
    end
    if (longint'(V_TOTAL - 1) >= (longint'(1) << VCOUNT_WIDTH)) begin : g_v_width_err
        $error("display_timing_gen: VCOUNT_WIDTH too small for V_TOTAL-1");
    end
    if (CLK_DIV < 1) begin : g_div_err
        $error("display_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0]             div_q, div_d;
    logic [HCOUNT_WIDTH-1:0]      h_q, h_d;
    logic [VCOUNT_WIDTH-1:0]      v_q, v_d;
    logic [FRAME_COUNT_WIDTH-1:0] fc_q, fc_d;
    logic                         tick, h_wrap, v_wrap;
    logic                         hsync_d, vsync_d, hblank_d, vblank_d;
    logic                         pix_en_q, hsync_q, vsync_q, hblank_q, vblank_q;
    logic                         line_start_q, frame_start_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    always_comb begin
        div_d  = div_q;
        h_d    = h_q;
        v_d    = v_q;
        fc_d   = fc_q;
        tick   = 1'b0;
        h_wrap = 1'b0;
        v_wrap = 1'b0;

        if (enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            // The pixel advances on the edge that brings the divider to its
            // terminal count, so pix_en and the new position appear together.
            tick  = (div_d == DIV_LAST);
        end

        if (tick) begin
            if (h_q == H_LAST) begin
                h_d    = '0;
                h_wrap = 1'b1;
                if (v_q == V_LAST) begin
                    v_d    = '0;
                    v_wrap = 1'b1;
                    fc_d   = fc_q + FRAME_COUNT_WIDTH'(1);
                end else begin
                    v_d = v_q + VCOUNT_WIDTH'(1);
                end
            end else begin
                h_d = h_q + HCOUNT_WIDTH'(1);
            end
        end

        // Decode from the next position so the registered flags line up
        // with the registered position.
        hsync_d  = (int'(h_d) < H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = (int'(v_d) < V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        hblank_d = (int'(h_d) < HVIS0) || (int'(h_d) >= HVIS1);
        vblank_d = (int'(v_d) < VVIS0) || (int'(v_d) >= VVIS1);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            fc_q          <= '0;
            pix_en_q      <= 1'b0;
            hsync_q       <= HSYNC_POL;
            vsync_q       <= VSYNC_POL;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            fc_q          <= fc_d;
            pix_en_q      <= tick;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

`ifdef DISPLAY_TIMING_LINE_IRQ_EN
    logic line_irq_q;

    // line_cmp is sampled only at the line boundary that raises the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_irq_q <= 1'b0;
        end else begin
            line_irq_q <= h_wrap && (v_d == line_cmp);
        end
    end

    assign line_irq = line_irq_q;
`endif

    assign pix_en      = pix_en_q;
    assign h_pos       = h_q;
    assign v_pos       = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_display_timing_gen
//
// Three instances of display_timing_gen, one per mode:
//   u_def  default 800x525 mode, CLK_DIV=2
//   u_cus  20x7 mode, CLK_DIV=1, HSYNC_POL=1, FRAME_COUNT_WIDTH=2
//   u_rnd  12x7 mode, CLK_DIV=3, VSYNC_POL=1, driven by random enable/reset
// A reference model per instance counts enabled clocks and emitted pixels and
// derives every output arithmetically from those counts. Its prediction is
// compared each cycle. Hand-written sequences and a vector table cover the
// hold/resume, asynchronous reset and frame-wrap corner cases.
// -----------------------------------------------------------------------------
module tb_display_timing_gen;

    typedef struct packed {
        int ht; int vt; int hs; int hv0; int hv1; int vs; int vv0; int vv1;
        bit hpol; bit vpol; int fcw;
    } cfg_t;

    typedef struct packed {
        int h; int v; bit hs; bit vs; bit hb; bit vb; bit pix; bit ls; bit fs;
        int fc; bit irq;
    } exp_t;

    typedef struct packed {
        int clks; bit en; int h; int v; bit hs; bit vs; bit hb; bit vb;
        bit pix; bit ls; bit fs; int fc;
    } vec_t;

    localparam cfg_t CFG_A = '{ht:800, vt:525, hs:96, hv0:96+48, hv1:96+48+640,
                               vs:2, vv0:2+33, vv1:2+33+480, hpol:1'b0, vpol:1'b0, fcw:16};
    localparam cfg_t CFG_B = '{ht:20, vt:7, hs:4, hv0:8, hv1:16,
                               vs:1, vv0:2, vv1:6, hpol:1'b1, vpol:1'b0, fcw:2};
    localparam cfg_t CFG_C = '{ht:12, vt:7, hs:3, hv0:5, hv1:10,
                               vs:2, vv0:3, vv1:6, hpol:1'b0, vpol:1'b1, fcw:3};
    localparam int D_A = 2;
    localparam int D_B = 1;
    localparam int D_C = 3;

    int n_checks = 0;
    int n_errs   = 0;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    // ---------------- instance signals ----------------
    logic rst_a = 1'b1, en_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0;
    logic rst_c = 1'b1, en_c = 1'b0;
    logic [9:0] lc_a = 10'd100;
    logic [9:0] lc_b = 10'd3;
    logic [2:0] lc_c = 3'd2;

    logic        pix_en_a, hsync_a, vsync_a, hblank_a, vblank_a, line_start_a, frame_start_a;
    logic [9:0]  h_pos_a, v_pos_a;
    logic [15:0] fc_a;
    logic        pix_en_b, hsync_b, vsync_b, hblank_b, vblank_b, line_start_b, frame_start_b;
    logic [9:0]  h_pos_b, v_pos_b;
    logic [1:0]  fc_b;
    logic        pix_en_c, hsync_c, vsync_c, hblank_c, vblank_c, line_start_c, frame_start_c;
    logic [3:0]  h_pos_c;
    logic [2:0]  v_pos_c;
    logic [2:0]  fc_c;
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
    logic line_irq_a, line_irq_b, line_irq_c;
`endif

    display_timing_gen #(.CLK_DIV(D_A)) u_def (
        .clk(clk), .reset(rst_a), .enable(en_a),
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
        .line_cmp(lc_a), .line_irq(line_irq_a),
`endif
        .pix_en(pix_en_a), .h_pos(h_pos_a), .v_pos(v_pos_a), .hsync(hsync_a),
        .vsync(vsync_a), .hblank(hblank_a), .vblank(vblank_a),
        .line_start(line_start_a), .frame_start(frame_start_a), .frame_count(fc_a)
    );

    display_timing_gen #(
        .H_SYNC(4), .H_BACK(4), .H_VISIBLE(8), .H_FRONT(4),
        .V_SYNC(1), .V_BACK(1), .V_VISIBLE(4), .V_FRONT(1),
        .CLK_DIV(D_B), .HSYNC_POL(1'b1), .FRAME_COUNT_WIDTH(2)
    ) u_cus (
        .clk(clk), .reset(rst_b), .enable(en_b),
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
        .line_cmp(lc_b), .line_irq(line_irq_b),
`endif
        .pix_en(pix_en_b), .h_pos(h_pos_b), .v_pos(v_pos_b), .hsync(hsync_b),
        .vsync(vsync_b), .hblank(hblank_b), .vblank(vblank_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .frame_count(fc_b)
    );

    display_timing_gen #(
        .HCOUNT_WIDTH(4), .VCOUNT_WIDTH(3),
        .H_SYNC(3), .H_BACK(2), .H_VISIBLE(5), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_VISIBLE(3), .V_FRONT(1),
        .CLK_DIV(D_C), .VSYNC_POL(1'b1), .FRAME_COUNT_WIDTH(3)
    ) u_rnd (
        .clk(clk), .reset(rst_c), .enable(en_c),
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
        .line_cmp(lc_c), .line_irq(line_irq_c),
`endif
        .pix_en(pix_en_c), .h_pos(h_pos_c), .v_pos(v_pos_c), .hsync(hsync_c),
        .vsync(vsync_c), .hblank(hblank_c), .vblank(vblank_c),
        .line_start(line_start_c), .frame_start(frame_start_c), .frame_count(fc_c)
    );

    // ---------------- checking helpers ----------------
    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the number of pixels emitted since reset.
    function automatic exp_t model(cfg_t c, longint n, bit pix, int lc);
        exp_t r;
        longint frame_len = longint'(c.ht) * c.vt;
        r.h   = int'(n % c.ht);
        r.v   = int'((n / c.ht) % c.vt);
        r.fc  = int'((n / frame_len) % (longint'(1) << c.fcw));
        r.hs  = (r.h < c.hs) ? c.hpol : !c.hpol;
        r.vs  = (r.v < c.vs) ? c.vpol : !c.vpol;
        r.hb  = (r.h < c.hv0) || (r.h >= c.hv1);
        r.vb  = (r.v < c.vv0) || (r.v >= c.vv1);
        r.pix = pix;
        r.ls  = pix && (r.h == 0);
        r.fs  = r.ls && (r.v == 0);
        r.irq = r.ls && (r.v == lc);
        return r;
    endfunction

    task automatic check_out(string tag, exp_t e, longint h, longint v, logic hs, logic vs,
                             logic hb, logic vb, logic pix, logic ls, logic fs, longint fc);
        check({tag, ".h_pos"}, h, e.h);
        check({tag, ".v_pos"}, v, e.v);
        check({tag, ".hsync"}, hs, e.hs);
        check({tag, ".vsync"}, vs, e.vs);
        check({tag, ".hblank"}, hb, e.hb);
        check({tag, ".vblank"}, vb, e.vb);
        check({tag, ".pix_en"}, pix, e.pix);
        check({tag, ".line_start"}, ls, e.ls);
        check({tag, ".frame_start"}, fs, e.fs);
        check({tag, ".frame_count"}, fc, e.fc);
    endtask

    // Advance k cycles; inputs change 1 time unit after the falling edge.
    task automatic step(int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    // ---------------- reference models ----------------
    // e_* = enabled clocks since reset (divider = e mod CLK_DIV),
    // n_* = pixels emitted since reset; pix when the divider reaches CLK_DIV-1.
    longint e_a = 0, n_a = 0, e_b = 0, n_b = 0, e_c = 0, n_c = 0;
    bit     pix_a = 0, pix_b = 0, pix_c = 0;
    int     lcs_a = 0, lcs_b = 0, lcs_c = 0;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            e_a <= 0; n_a <= 0; pix_a <= 0;
        end else if (en_a) begin
            e_a   <= e_a + 1;
            pix_a <= ((e_a + 1) % D_A) == D_A - 1;
            if (((e_a + 1) % D_A) == D_A - 1) n_a <= n_a + 1;
            lcs_a <= int'(lc_a);
        end else begin
            pix_a <= 0;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            e_b <= 0; n_b <= 0; pix_b <= 0;
        end else if (en_b) begin
            e_b   <= e_b + 1;
            pix_b <= ((e_b + 1) % D_B) == D_B - 1;
            if (((e_b + 1) % D_B) == D_B - 1) n_b <= n_b + 1;
            lcs_b <= int'(lc_b);
        end else begin
            pix_b <= 0;
        end
    end

    always @(posedge clk or negedge rst_c) begin
        if (!rst_c) begin
            e_c <= 0; n_c <= 0; pix_c <= 0;
        end else if (en_c) begin
            e_c   <= e_c + 1;
            pix_c <= ((e_c + 1) % D_C) == D_C - 1;
            if (((e_c + 1) % D_C) == D_C - 1) n_c <= n_c + 1;
            lcs_c <= int'(lc_c);
        end else begin
            pix_c <= 0;
        end
    end

    exp_t ea, eb, ec;

    always @(negedge clk) begin
        ea = model(CFG_A, n_a, pix_a, lcs_a);
        check_out("def", ea, h_pos_a, v_pos_a, hsync_a, vsync_a, hblank_a, vblank_a,
                  pix_en_a, line_start_a, frame_start_a, fc_a);
        eb = model(CFG_B, n_b, pix_b, lcs_b);
        check_out("cus", eb, h_pos_b, v_pos_b, hsync_b, vsync_b, hblank_b, vblank_b,
                  pix_en_b, line_start_b, frame_start_b, fc_b);
        ec = model(CFG_C, n_c, pix_c, lcs_c);
        check_out("rnd", ec, h_pos_c, v_pos_c, hsync_c, vsync_c, hblank_c, vblank_c,
                  pix_en_c, line_start_c, frame_start_c, fc_c);
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
        check("def.line_irq", line_irq_a, ea.irq);
        check("cus.line_irq", line_irq_b, eb.irq);
        check("rnd.line_irq", line_irq_c, ec.irq);
`endif
    end

    // ---------------- vector table for the 20x7 mode ----------------
    // Each row: run 'clks' cycles with enable 'en' (cumulative from reset
    // release), then expect the listed outputs.
    vec_t vecs [14];

    initial begin
        bit found;
        int cnt;
        int irqs;

        //            clks en  h  v hs vs hb vb pix ls fs fc
        vecs[0]  = '{0,   1,  0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{3,   1,  3, 0, 1, 0, 1, 1, 1, 0, 0, 0};
        vecs[2]  = '{1,   1,  4, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{4,   1,  8, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[4]  = '{8,   1, 16, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        vecs[5]  = '{4,   1,  0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        vecs[6]  = '{20,  1,  0, 2, 1, 1, 1, 0, 1, 1, 0, 0};
        vecs[7]  = '{5,   0,  0, 2, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{85,  1,  5, 6, 0, 1, 1, 1, 1, 0, 0, 0};
        vecs[9]  = '{15,  1,  0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
        vecs[10] = '{140, 1,  0, 0, 1, 0, 1, 1, 1, 1, 1, 2};
        vecs[11] = '{140, 1,  0, 0, 1, 0, 1, 1, 1, 1, 1, 3};
        vecs[12] = '{140, 1,  0, 0, 1, 0, 1, 1, 1, 1, 1, 0};
        vecs[13] = '{140, 1,  0, 0, 1, 0, 1, 1, 1, 1, 1, 1};

        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        step(3);

        // ---- reset state of the default mode ----
        check("def.rst.h_pos", h_pos_a, 0);
        check("def.rst.v_pos", v_pos_a, 0);
        check("def.rst.hsync", hsync_a, 0);
        check("def.rst.vsync", vsync_a, 0);
        check("def.rst.hblank", hblank_a, 1);
        check("def.rst.vblank", vblank_a, 1);
        check("def.rst.pix_en", pix_en_a, 0);
        check("def.rst.frame_count", fc_a, 0);

        // ---- default mode: run line 0, hold at h_pos=799 ----
        rst_a = 1'b1;
        en_a  = 1'b1;
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step(1);
            if (pix_en_a && h_pos_a == 10'd799) found = 1;
        end
        check("def.reach_799", found, 1);
        en_a = 1'b0;
        for (int i = 0; i < 37; i++) begin
            step(1);
            check("def.hold.h_pos", h_pos_a, 799);
            check("def.hold.v_pos", v_pos_a, 0);
            check("def.hold.pix_en", pix_en_a, 0);
            check("def.hold.line_start", line_start_a, 0);
        end
        en_a  = 1'b1;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            step(1);
            if (pix_en_a) found = 1;
        end
        check("def.resume.pix_seen", found, 1);
        check("def.resume.h_pos", h_pos_a, 0);
        check("def.resume.v_pos", v_pos_a, 1);
        check("def.resume.line_start", line_start_a, 1);
        check("def.resume.frame_start", frame_start_a, 0);

        // ---- default mode: asynchronous reset mid-line ----
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1);
            if (h_pos_a == 10'd300) found = 1;
        end
        check("def.reach_300", found, 1);
        rst_a = 1'b0;
        #1;
        check("def.async.h_pos", h_pos_a, 0);
        check("def.async.v_pos", v_pos_a, 0);
        check("def.async.pix_en", pix_en_a, 0);
        check("def.async.hsync", hsync_a, 0);
        check("def.async.vsync", vsync_a, 0);
        check("def.async.hblank", hblank_a, 1);
        check("def.async.vblank", vblank_a, 1);
        check("def.async.line_start", line_start_a, 0);
        step(1);
        rst_a = 1'b1;
        check("def.release.h_pos", h_pos_a, 0);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            step(1);
            if (pix_en_a) found = 1;
        end
        check("def.release.pix_seen", found, 1);
        check("def.release.first_h", h_pos_a, 1);
        step(300);
        en_a = 1'b0;

        // ---- 20x7 mode: vector table ----
        rst_b = 1'b1;
        for (int i = 0; i < 14; i++) begin
            en_b = vecs[i].en;
            step(vecs[i].clks);
            check($sformatf("cus.vec%0d.h_pos", i), h_pos_b, vecs[i].h);
            check($sformatf("cus.vec%0d.v_pos", i), v_pos_b, vecs[i].v);
            check($sformatf("cus.vec%0d.hsync", i), hsync_b, vecs[i].hs);
            check($sformatf("cus.vec%0d.vsync", i), vsync_b, vecs[i].vs);
            check($sformatf("cus.vec%0d.hblank", i), hblank_b, vecs[i].hb);
            check($sformatf("cus.vec%0d.vblank", i), vblank_b, vecs[i].vb);
            check($sformatf("cus.vec%0d.pix_en", i), pix_en_b, vecs[i].pix);
            check($sformatf("cus.vec%0d.line_start", i), line_start_b, vecs[i].ls);
            check($sformatf("cus.vec%0d.frame_start", i), frame_start_b, vecs[i].fs);
            check($sformatf("cus.vec%0d.frame_count", i), fc_b, vecs[i].fc);
        end

        // ---- 20x7 mode: frame_start period, one line_irq per frame ----
        for (int f = 0; f < 2; f++) begin
            cnt   = 0;
            irqs  = 0;
            found = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                step(1);
                cnt++;
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
                if (line_irq_b) irqs++;
`endif
                if (frame_start_b) found = 1;
            end
            check("cus.frame_start_seen", found, 1);
            check("cus.frame_period", cnt, 140);
`ifdef DISPLAY_TIMING_LINE_IRQ_EN
            check("cus.irq_per_frame", irqs, 1);
`endif
        end
        en_b = 1'b0;

        // ---- 12x7 mode, CLK_DIV=3: random enable, compare and rare resets ----
        rst_c = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            en_c = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) lc_c = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) begin
                rst_c = 1'b0;
                #1;
                rst_c = 1'b1;
            end
            step(1);
        end
        en_c = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
